cpu_rx_buffer: RTL

- CPU-side receive stage; sits directly downstream of the peripheral's `send`/`ack`/4-bit `data` link.
- Performs a four-phase handshake on that link and synchronises `send` into the local clock domain.
- Pairs consecutive nibbles into bytes and queues them in a small FIFO.
- Presents the bytes to CPU logic through a valid/ready port.

---
 rtl/cpu_rx_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/cpu_rx_buffer.sv
`default_nettype none
// cpu_rx_buffer: four-phase nibble receiver with a send synchroniser. It pairs nibbles
// into bytes, queues them in a DEPTH-entry FIFO and offers them on a valid/ready port.
module cpu_rx_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send,
    input  logic [3:0]       data,
    output logic             ack,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [CNT_W-1:0] count,
    output logic             half
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       ACKING   = 1'b1;

    logic             s1_q;
    logic             s2_q;
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             half_q;
    logic             half_d;
    logic [3:0]       lo_q;
    logic [3:0]       lo_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             capture;
    logic             push;
    logic             pop;

    // A pending high nibble is only taken when the FIFO has room; otherwise ack is withheld.
    always_comb begin
        capture = (state_q == IDLE) && s2_q && (!half_q || (count_q < FULL_CNT));
        push    = capture && half_q;
        pop     = (count_q != '0) && byte_ready;

        state_d = state_q;
        half_d  = half_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = ACKING;
                    half_d  = !half_q;
                    if (!half_q) begin
                        lo_d = data;
                    end
                end
            end
            default: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end
            end
        endcase

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= IDLE;
            half_q   <= 1'b0;
            lo_q     <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            s1_q    <= send;
            s2_q    <= s1_q;
            state_q <= state_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {data, lo_q};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign ack        = (state_q == ACKING);
    assign half       = half_q;
    assign count      = count_q;
    assign byte_valid = (count_q != '0);
    assign byte_out   = mem_q[rd_ptr_q];

endmodule
`default_nettype wire
